rect_motion_ctrl: RTL and testbench
===================================

Name: rect_motion_ctrl

Overview:
Frame-synchronous motion controller for the on-screen rectangle in the 640x480 HDMI test pattern. It holds the rectangle centre, direction and speed. Once per frame strobe it advances the centre and bounces it off the display edges. It presents registered edge co-ordinates to the pixel compare logic. A valid/ready config port lets a host load a new position, direction or speed between updates.

Parameters:
H_WIDTH, 100, rectangle width in pixels
H_HEIGHT, 75, rectangle height in pixels
IX, 320, reset centre x
IY, 240, reset centre y
IX_DIR, 1, reset x direction (1 = right, 0 = left)
IY_DIR, 1, reset y direction (1 = down, 0 = up)
ISTEP, 1, reset step in pixels per frame (0-15)
D_WIDTH, 640, display width
D_HEIGHT, 480, display height

Ports:
i_clk  in  1  pixel/base clock
i_rst_n  in  1  asynchronous active-low reset
i_frame_stb  in  1  one-cycle pulse at start of vertical blanking
i_animate  in  1  motion enabled when high
i_cfg_valid  in  1  config request
o_cfg_ready  out  1  config accepted when valid and ready are both high
i_cfg_x  in  12  new centre x
i_cfg_y  in  12  new centre y
i_cfg_x_dir  in  1  new x direction
i_cfg_y_dir  in  1  new y direction
i_cfg_step  in  4  new step
o_x1  out  12  left edge
o_x2  out  12  right edge
o_y1  out  12  top edge
o_y2  out  12  bottom edge
o_busy  out  1  high while an update is in flight

Behaviour:
- Limits: XMIN = H_WIDTH/2 and XMAX = D_WIDTH-1-H_WIDTH/2, giving 50 and 589 at the defaults. YMIN = H_HEIGHT/2 and YMAX = D_HEIGHT-1-H_HEIGHT/2, giving 37 and 442. All arithmetic is 12-bit unsigned with integer halving.
- Reset (async assert, sync deassert, no other clocked action):
  - x=IX, y=IY, dirs=IX_DIR/IY_DIR, step=ISTEP, state IDLE.
  - Outputs are 270/370/203/277 at the defaults.
  - o_busy=0, o_cfg_ready=1.
- FSM IDLE -> CALC -> COMMIT -> IDLE:
  - IDLE: o_cfg_ready=1.
    - If i_cfg_valid is high, load the config into x/y/dir/step and go to COMMIT. Config has priority over a simultaneous i_frame_stb, and that strobe is dropped.
    - Else, if i_frame_stb and i_animate are both high, go to CALC.
    - Else stay in IDLE.
  - CALC: o_busy=1, o_cfg_ready=0. Compute and register the next x/dir and y/dir. Frame strobes arriving here are ignored.
  - COMMIT: o_busy=1, o_cfg_ready=0. Register o_x1=x-H_WIDTH/2, o_x2=x+H_WIDTH/2, o_y1=y-H_HEIGHT/2, o_y2=y+H_HEIGHT/2, then return to IDLE.
- Latency:
  - Strobe at cycle N gives new edges visible at N+3.
  - Config handshake at cycle N gives new edges at N+2.
- Edge outputs change only in COMMIT, so they never tear mid-frame.
- Axis step, with p = position, s = step:
  - Moving positive: if p+s >= MAX then p=MAX and dir flips to 0, else p=p+s.
  - Moving negative: if p <= MIN+s then p=MIN and dir flips to 1, else p=p-s.
  - s=0 means p is unchanged and dir is unchanged.
- Config clamp: a loaded x or y outside [MIN,MAX] is clamped to the nearest limit. The direction is loaded as given.
- A position exactly at a limit moving outward is held at the limit and flips direction in the same update.
- i_animate low: strobes are ignored, while config is still accepted.
- Reset mid-CALC/COMMIT aborts the update and restores the reset values immediately.

Optional Feature:
RECT_BOUNCE_CNT_EN
- Defined: adds output o_bounce_cnt [15:0]. It increments by 1 (wrapping) in COMMIT for each axis that flipped in that update, so a corner hit adds 2. It resets to 0 and a config load clears it.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package rect_pkg: state enum (IDLE, CALC, COMMIT), display defaults 640/480, COORD_W=12, STEP_W=4.
- Sub-module rect_axis_step: combinational next position and direction, plus a flip flag, from (p, dir, s, MIN, MAX). Two instances, x and y. Clamp logic lives in the parent.

Test Plan:
1. Release reset and wait. Outputs must read 270/370/203/277, with o_cfg_ready=1 and o_busy=0.
2. i_animate=1 and one strobe. o_x1=271, o_y1=204 exactly 3 cycles after the strobe, and o_busy is high for 2 cycles.
3. Config x=588, x_dir=1, step=4, then strobe. x=589 (o_x2=639) with x_dir=0. The next strobe gives x=585.
4. Config x=10, y=500. Clamped to x=50, y=442, so o_x1=0 and o_y2=479 two cycles after the handshake.
5. i_cfg_valid and i_frame_stb in the same IDLE cycle. The config is applied and there is no motion step. A strobe during CALC has no effect, and with i_animate=0 strobes produce no change.
6. Assert i_rst_n low during CALC. Outputs return to reset values asynchronously and the FSM is in IDLE. With RECT_BOUNCE_CNT_EN, a corner config (589, 442, dirs 1/1) plus one strobe gives o_bounce_cnt=2.

Source files
------------

// File: rtl/rect_pkg.sv
// Shared types and constants for the rectangle motion controller.
package rect_pkg;

    // Co-ordinate and step widths
    localparam int unsigned COORD_W = 12;
    localparam int unsigned STEP_W  = 4;

    // Display defaults for the 640x480 test pattern
    localparam int unsigned DISP_W_DEF = 640;
    localparam int unsigned DISP_H_DEF = 480;

    // Update sequencer states
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCalc   = 2'd1,
        StCommit = 2'd2
    } rect_state_e;

endpackage

// File: rtl/rect_axis_step.sv
// One-axis motion step: advances a position by the step in the current
// direction and bounces it off [min, max], flagging a direction flip.
module rect_axis_step
    import rect_pkg::*;
(
    input  logic [COORD_W-1:0] i_p,
    input  logic               i_dir,
    input  logic [STEP_W-1:0]  i_s,
    input  logic [COORD_W-1:0] i_min,
    input  logic [COORD_W-1:0] i_max,
    output logic [COORD_W-1:0] o_p,
    output logic               o_dir,
    output logic               o_flip
);

    logic [COORD_W-1:0] s_ext;
    assign s_ext = {{(COORD_W - STEP_W){1'b0}}, i_s};

    // Positions are always held inside [min, max], so p+s and min+s never wrap.
    always_comb begin
        o_p    = i_p;
        o_dir  = i_dir;
        o_flip = 1'b0;
        if (i_s != '0) begin
            if (i_dir) begin
                if (i_p + s_ext >= i_max) begin
                    o_p    = i_max;
                    o_dir  = 1'b0;
                    o_flip = 1'b1;
                end else begin
                    o_p = i_p + s_ext;
                end
            end else begin
                if (i_p <= i_min + s_ext) begin
                    o_p    = i_min;
                    o_dir  = 1'b1;
                    o_flip = 1'b1;
                end else begin
                    o_p = i_p - s_ext;
                end
            end
        end
    end

endmodule

// File: rtl/rect_motion_ctrl.sv
// Frame-synchronous bouncing-rectangle controller. Advances the centre once
// per frame strobe, accepts host config in IDLE, and publishes edges only in
// COMMIT so the pixel compare never sees a half-updated rectangle.
// Optional macro RECT_BOUNCE_CNT_EN adds o_bounce_cnt (axis flips per update).
module rect_motion_ctrl
    import rect_pkg::*;
#(
    parameter int unsigned H_WIDTH  = 100,
    parameter int unsigned H_HEIGHT = 75,
    parameter int unsigned IX       = 320,
    parameter int unsigned IY       = 240,
    parameter bit          IX_DIR   = 1'b1,
    parameter bit          IY_DIR   = 1'b1,
    parameter int unsigned ISTEP    = 1,
    parameter int unsigned D_WIDTH  = DISP_W_DEF,
    parameter int unsigned D_HEIGHT = DISP_H_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_frame_stb,
    input  logic               i_animate,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [COORD_W-1:0] i_cfg_x,
    input  logic [COORD_W-1:0] i_cfg_y,
    input  logic               i_cfg_x_dir,
    input  logic               i_cfg_y_dir,
    input  logic [STEP_W-1:0]  i_cfg_step,
    output logic [COORD_W-1:0] o_x1,
    output logic [COORD_W-1:0] o_x2,
    output logic [COORD_W-1:0] o_y1,
    output logic [COORD_W-1:0] o_y2,
    output logic               o_busy
`ifdef RECT_BOUNCE_CNT_EN
    ,
    output logic [15:0]        o_bounce_cnt
`endif
);

    localparam logic [COORD_W-1:0] HALF_W = COORD_W'(H_WIDTH / 2);
    localparam logic [COORD_W-1:0] HALF_H = COORD_W'(H_HEIGHT / 2);
    localparam logic [COORD_W-1:0] XMIN   = HALF_W;
    localparam logic [COORD_W-1:0] XMAX   = COORD_W'(D_WIDTH - 1 - H_WIDTH / 2);
    localparam logic [COORD_W-1:0] YMIN   = HALF_H;
    localparam logic [COORD_W-1:0] YMAX   = COORD_W'(D_HEIGHT - 1 - H_HEIGHT / 2);
    localparam logic [COORD_W-1:0] RST_X  = COORD_W'(IX);
    localparam logic [COORD_W-1:0] RST_Y  = COORD_W'(IY);
    localparam logic [STEP_W-1:0]  RST_S  = STEP_W'(ISTEP);

    rect_state_e        state_q;
    logic [COORD_W-1:0] x_q, y_q;
    logic               xdir_q, ydir_q;
    logic [STEP_W-1:0]  step_q;
    logic [COORD_W-1:0] x1_q, x2_q, y1_q, y2_q;
    logic               busy_q, ready_q;

    logic [COORD_W-1:0] x_nxt, y_nxt;
    logic               xdir_nxt, ydir_nxt, x_flip, y_flip;
    logic [COORD_W-1:0] cfg_x_clamped, cfg_y_clamped;

    rect_axis_step u_axis_x (
        .i_p    (x_q),
        .i_dir  (xdir_q),
        .i_s    (step_q),
        .i_min  (XMIN),
        .i_max  (XMAX),
        .o_p    (x_nxt),
        .o_dir  (xdir_nxt),
        .o_flip (x_flip)
    );

    rect_axis_step u_axis_y (
        .i_p    (y_q),
        .i_dir  (ydir_q),
        .i_s    (step_q),
        .i_min  (YMIN),
        .i_max  (YMAX),
        .o_p    (y_nxt),
        .o_dir  (ydir_nxt),
        .o_flip (y_flip)
    );

    // Clamp host-supplied centre into the legal travel range
    always_comb begin
        cfg_x_clamped = i_cfg_x;
        cfg_y_clamped = i_cfg_y;
        if (i_cfg_x < XMIN) cfg_x_clamped = XMIN;
        else if (i_cfg_x > XMAX) cfg_x_clamped = XMAX;
        if (i_cfg_y < YMIN) cfg_y_clamped = YMIN;
        else if (i_cfg_y > YMAX) cfg_y_clamped = YMAX;
    end

    // Update sequencer: IDLE -> (CALC) -> COMMIT -> IDLE, with registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            x_q     <= RST_X;
            y_q     <= RST_Y;
            xdir_q  <= IX_DIR;
            ydir_q  <= IY_DIR;
            step_q  <= RST_S;
            x1_q    <= RST_X - HALF_W;
            x2_q    <= RST_X + HALF_W;
            y1_q    <= RST_Y - HALF_H;
            y2_q    <= RST_Y + HALF_H;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Config wins over a coincident strobe; that strobe is lost
                    if (i_cfg_valid) begin
                        x_q     <= cfg_x_clamped;
                        y_q     <= cfg_y_clamped;
                        xdir_q  <= i_cfg_x_dir;
                        ydir_q  <= i_cfg_y_dir;
                        step_q  <= i_cfg_step;
                        state_q <= StCommit;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end else if (i_frame_stb && i_animate) begin
                        state_q <= StCalc;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                StCalc: begin
                    x_q     <= x_nxt;
                    xdir_q  <= xdir_nxt;
                    y_q     <= y_nxt;
                    ydir_q  <= ydir_nxt;
                    state_q <= StCommit;
                end
                StCommit: begin
                    x1_q    <= x_q - HALF_W;
                    x2_q    <= x_q + HALF_W;
                    y1_q    <= y_q - HALF_H;
                    y2_q    <= y_q + HALF_H;
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_x1        = x1_q;
    assign o_x2        = x2_q;
    assign o_y1        = y1_q;
    assign o_y2        = y2_q;
    assign o_busy      = busy_q;
    assign o_cfg_ready = ready_q;

`ifdef RECT_BOUNCE_CNT_EN
    logic        flip_x_q, flip_y_q;
    logic [15:0] bounce_cnt_q;

    // Capture flips in CALC, fold them into the counter in COMMIT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flip_x_q     <= 1'b0;
            flip_y_q     <= 1'b0;
            bounce_cnt_q <= '0;
        end else if (state_q == StIdle && i_cfg_valid) begin
            flip_x_q     <= 1'b0;
            flip_y_q     <= 1'b0;
            bounce_cnt_q <= '0;
        end else if (state_q == StCalc) begin
            flip_x_q <= x_flip;
            flip_y_q <= y_flip;
        end else if (state_q == StCommit) begin
            bounce_cnt_q <= bounce_cnt_q + {15'd0, flip_x_q} + {15'd0, flip_y_q};
            flip_x_q     <= 1'b0;
            flip_y_q     <= 1'b0;
        end
    end

    assign o_bounce_cnt = bounce_cnt_q;
`else
    logic unused_flip;
    assign unused_flip = x_flip ^ y_flip;
`endif

endmodule

// File: tb/tb_rect_motion_ctrl.sv
// Self-checking bench for rect_motion_ctrl: a transaction-level model predicts
// every output each cycle, plus literal checkpoints from hand calculation.
module tb_rect_motion_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_stb = 1'b0;
    logic        animate = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [11:0] cfg_x = '0;
    logic [11:0] cfg_y = '0;
    logic        cfg_x_dir = 1'b0;
    logic        cfg_y_dir = 1'b0;
    logic [3:0]  cfg_step = '0;
    logic [11:0] x1, x2, y1, y2;
    logic        busy;
`ifdef RECT_BOUNCE_CNT_EN
    logic [15:0] bounce_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    rect_motion_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_frame_stb (frame_stb),
        .i_animate   (animate),
        .i_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .i_cfg_x     (cfg_x),
        .i_cfg_y     (cfg_y),
        .i_cfg_x_dir (cfg_x_dir),
        .i_cfg_y_dir (cfg_y_dir),
        .i_cfg_step  (cfg_step),
        .o_x1        (x1),
        .o_x2        (x2),
        .o_y1        (y1),
        .o_y2        (y2),
        .o_busy      (busy)
`ifdef RECT_BOUNCE_CNT_EN
        ,
        .o_bounce_cnt(bounce_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int XMIN = 50, XMAX = 589, YMIN = 37, YMAX = 442;
    int mx, my, mxd, myd, ms;      // model position state
    int vx, vy;                    // centre currently shown on the edge outputs
    int px, py;                    // centre waiting to be shown
    int inflight;                  // cycles until the pending centre is shown
    int mcnt, pflips;

    task automatic mdl_reset();
        mx = 320; my = 240; mxd = 1; myd = 1; ms = 1;
        vx = 320; vy = 240; px = 320; py = 240;
        inflight = 0; mcnt = 0; pflips = 0;
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Move one axis; returns 1 if the direction reversed
    task automatic move(inout int p, inout int d, input int s, input int lo, input int hi,
                        output int flipped);
        flipped = 0;
        if (s == 0) return;
        if (d == 1) begin
            if (p + s >= hi) begin p = hi; d = 0; flipped = 1; end
            else p = p + s;
        end else begin
            if (p <= lo + s) begin p = lo; d = 1; flipped = 1; end
            else p = p - s;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        int fx, fy;
        if (!rst_n) begin
            mdl_reset();
        end else if (inflight > 0) begin
            inflight--;
            if (inflight == 0) begin
                vx = px; vy = py;
                mcnt = (mcnt + pflips) % 65536;
            end
        end else if (cfg_valid) begin
            mx = clampi(int'(cfg_x), XMIN, XMAX);
            my = clampi(int'(cfg_y), YMIN, YMAX);
            mxd = int'(cfg_x_dir); myd = int'(cfg_y_dir); ms = int'(cfg_step);
            px = mx; py = my; pflips = 0; mcnt = 0;
            inflight = 1;
        end else if (frame_stb && animate) begin
            move(mx, mxd, ms, XMIN, XMAX, fx);
            move(my, myd, ms, YMIN, YMAX, fy);
            px = mx; py = my; pflips = fx + fy;
            inflight = 2;
        end
    end

    // Every-cycle compare against the model
    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("x1", int'(x1), vx - 50);
            chk("x2", int'(x2), vx + 50);
            chk("y1", int'(y1), vy - 37);
            chk("y2", int'(y2), vy + 37);
            chk("busy", int'(busy), (inflight > 0) ? 1 : 0);
            chk("cfg_ready", int'(cfg_ready), (inflight == 0) ? 1 : 0);
`ifdef RECT_BOUNCE_CNT_EN
            chk("bounce_cnt", int'(bounce_cnt), mcnt);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        frame_stb = 1'b1;
        tick();
        frame_stb = 1'b0;
    endtask

    task automatic config_load(input int x, input int y, input bit xd, input bit yd,
                               input int s);
        cfg_x = 12'(x); cfg_y = 12'(y); cfg_x_dir = xd; cfg_y_dir = yd; cfg_step = 4'(s);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        mdl_reset();
        #12;
        rst_n = 1'b1;
        cmp_en = 1'b1;
        idle(2);

        // 1: reset state
        chk("rst_x1", int'(x1), 270);
        chk("rst_x2", int'(x2), 370);
        chk("rst_y1", int'(y1), 203);
        chk("rst_y2", int'(y2), 277);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_busy", int'(busy), 0);

        // 2: single strobe, 3-cycle latency, busy for 2 cycles
        animate = 1'b1;
        strobe();
        @(negedge clk); chk("t2_busy_c1", int'(busy), 1);
        @(negedge clk); chk("t2_busy_c2", int'(busy), 1);
                        chk("t2_x1_early", int'(x1), 270);
        @(negedge clk); chk("t2_busy_c3", int'(busy), 0);
                        chk("t2_x1", int'(x1), 271);
                        chk("t2_y1", int'(y1), 204);
        tick();

        // 3: bounce off the right edge, then move back
        config_load(588, 241, 1'b1, 1'b1, 4);
        idle(2);
        strobe();
        idle(3);
        chk("t3_x2", int'(x2), 639);
        chk("t3_y1", int'(y1), 245 - 37);
        strobe();
        idle(3);
        chk("t3_x1_back", int'(x1), 535);

        // 4: config clamp, edges visible 2 cycles after handshake
        config_load(10, 500, 1'b0, 1'b0, 3);
        @(negedge clk); chk("t4_busy", int'(busy), 1);
        @(negedge clk); chk("t4_x1", int'(x1), 0);
                        chk("t4_y2", int'(y2), 479);
        tick();

        // 5: config beats coincident strobe; strobe in CALC ignored; animate low ignored
        cfg_x = 12'd300; cfg_y = 12'd200; cfg_x_dir = 1'b1; cfg_y_dir = 1'b1; cfg_step = 4'd2;
        cfg_valid = 1'b1; frame_stb = 1'b1;
        tick();
        cfg_valid = 1'b0; frame_stb = 1'b0;
        idle(4);
        chk("t5_cfg_x1", int'(x1), 250);
        chk("t5_cfg_y1", int'(y1), 163);
        strobe();
        strobe();            // lands in CALC
        idle(4);
        chk("t5_calc_x1", int'(x1), 252);
        animate = 1'b0;
        strobe();
        @(negedge clk); chk("t5_noanim_busy", int'(busy), 0);
        idle(3);
        chk("t5_noanim_x1", int'(x1), 252);
        animate = 1'b1;

        // 6: reset during CALC restores reset values immediately
        strobe();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_x1", int'(x1), 270);
        chk("t6_y2", int'(y2), 277);
        chk("t6_busy", int'(busy), 0);
        chk("t6_ready", int'(cfg_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        chk("t6_idle_x1", int'(x1), 270);

`ifdef RECT_BOUNCE_CNT_EN
        // Corner hit flips both axes
        config_load(589, 442, 1'b1, 1'b1, 1);
        idle(2);
        chk("bc_cleared", int'(bounce_cnt), 0);
        strobe();
        idle(3);
        chk("bc_corner", int'(bounce_cnt), 2);
`endif

        idle(2);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
